// File: rtl/stage_pipe_pkg.sv
// stage_pipe_pkg: shared constants, slice state encoding and the
// occupancy width helper for the stage pipe chain.
package stage_pipe_pkg;

    localparam int MAX_DEPTH = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } slice_state_e;

    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stage_pipe_chain_if.sv
// stage_pipe_chain_if: valid/ready payload bus with master and slave
// views, used on both ends of the stage pipe chain.
interface stage_pipe_chain_if #(
    parameter int DATA_W = 1024
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/stage_pipe_slice.sv
// stage_pipe_slice: one elastic register slice. SKID=1 is a 2-entry skid
// buffer with registered ready; SKID=0 is a 1-entry slice.
module stage_pipe_slice
    import stage_pipe_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    slice_state_e      state;
    slice_state_e      state_nx;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;
    logic              in_x;
    logic              out_x;

    assign m_valid = (state != S_EMPTY);
    assign m_data  = main_q;
    assign in_x    = s_valid & s_ready;
    assign out_x   = m_valid & m_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign s_ready = (state != S_FULL);
        end else begin : g_flow
            assign s_ready = (state == S_EMPTY) | m_ready;
        end
    endgenerate

    always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (in_x) begin
                    state_nx  = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (in_x && out_x) begin
                    load_main = 1'b1;
                end else if (in_x) begin
                    // only reachable with SKID=1: ready stays up while main waits
                    state_nx  = S_FULL;
                    load_skid = 1'b1;
                end else if (out_x) begin
                    state_nx = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_x) begin
                    state_nx       = S_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
        if (flush) begin
            state_nx       = S_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            if (load_main) begin
                main_q <= s_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/stage_pipe_chain.sv
// stage_pipe_chain: DEPTH elastic slices with flush and occupancy.
// Optional STAGE_PIPE_STATS_EN adds saturating xfer/stall counters.
module stage_pipe_chain
    import stage_pipe_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic                        axis_clk,
    input  logic                        areset,
    input  logic                        flush,
    stage_pipe_chain_if.slave           s,
    stage_pipe_chain_if.master          m,
    output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef STAGE_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]            xfer_cnt,
    output logic [CNT_W-1:0]            stall_cnt
`endif
);

    localparam int OCC_W = occ_width(DEPTH);
    // out-of-range depth clamps to the largest supported chain
    localparam int N = (DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEPTH;

    logic [DATA_W-1:0] d [N+1];
    logic              v [N+1];
    logic              r [N+1];
    logic              in_x;
    logic              out_x;

    assign d[0]    = s.data;
    assign v[0]    = s.valid;
    assign s.ready = r[0] & ~areset;
    assign m.data  = d[N];
    assign m.valid = v[N];
    assign r[N]    = m.ready;

    assign in_x  = s.valid & s.ready;
    assign out_x = m.valid & m.ready;

    generate
        for (genvar i = 0; i < N; i++) begin : g_slice
            stage_pipe_slice #(
                .DATA_W (DATA_W),
                .SKID   (SKID)
            ) u_slice (
                .clk     (axis_clk),
                .rst     (areset),
                .flush   (flush),
                .s_data  (d[i]),
                .s_valid (v[i]),
                .s_ready (r[i]),
                .m_data  (d[i+1]),
                .m_valid (v[i+1]),
                .m_ready (r[i+1])
            );
        end

        if (N == 0) begin : g_occ_none
            assign occupancy = '0;
        end else begin : g_occ
            always_ff @(posedge axis_clk) begin
                if (areset || flush) begin
                    occupancy <= '0;
                end else if (in_x && !out_x) begin
                    occupancy <= occupancy + OCC_W'(1);
                end else if (out_x && !in_x) begin
                    occupancy <= occupancy - OCC_W'(1);
                end
            end
        end
    endgenerate

`ifdef STAGE_PIPE_STATS_EN
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_x && !(&xfer_cnt)) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (m.valid && !m.ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
